// File: rtl/sep_conv_pkg.sv
// Shared definitions for the separable-convolution datapath: FSM state
// encoding, frame-size helpers and default channel count.
package sep_conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam int CHANNELS_DEFAULT = 16;

  function automatic int frame_pixels(input int img_w, input int img_h);
    return img_w * img_h;
  endfunction

  // A one-pixel frame still needs a 1-bit address.
  function automatic int addr_width(input int n_pix);
    return (n_pix <= 1) ? 1 : $clog2(n_pix);
  endfunction

endpackage

// File: rtl/frame_buffer_sdp_ram.sv
// Simple dual-port frame store: one write port, one synchronous read port.
// Only the read output register is reset; the array itself is not.
module frame_buffer_sdp_ram #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 1936,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register holds the last pixel while reads are stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/feature_map_frame_streamer.sv
// Captures one raster feature map from a gappy producer, then replays it as a
// dense stallable stream with a 1-cycle RAM read latency.
//
// state  | meaning
// IDLE   | empty buffer, waiting for pixel 0 (written at address 0)
// FILL   | capturing pixels 1..N-1 at wr_addr
// STREAM | replaying from rd_addr; input pixels are dropped (Overflow)
module feature_map_frame_streamer
  import sep_conv_pkg::*;
#(
  parameter int DATA_WIDHT = 32,
  parameter int CHANNELS   = CHANNELS_DEFAULT,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDHT*CHANNELS-1:0] Data_In,
  input  logic                           Valid_In,
  input  logic                           Stall_In,
  output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
  output logic                           Valid_Out,
  output logic                           Frame_Done,
  output logic                           Busy,
  output logic                           Overflow
);

  localparam int W  = DATA_WIDHT * CHANNELS;
  localparam int N  = frame_pixels(IMG_WIDHT, IMG_HEIGHT);
  localparam int AW = addr_width(N);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [AW-1:0] ONE       = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          overflow_q, overflow_d;
  logic          busy_q;
  logic          valid_q;
  logic          done_q;
  logic          wr_en;
  logic          rd_en;
  logic          last_rd;

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    last_rd    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Valid_In) begin
          wr_en = 1'b1;
          if (N == 1) begin
            wr_addr_d = '0;
            state_d   = STREAM;
          end else begin
            wr_addr_d = ONE;
            state_d   = FILL;
          end
        end
      end
      FILL: begin
        if (Valid_In) begin
          wr_en = 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            wr_addr_d = '0;
            state_d   = STREAM;
          end else begin
            wr_addr_d = wr_addr_q + ONE;
          end
        end
      end
      STREAM: begin
        // Still STREAM on the final read edge, so a pixel there is dropped too.
        if (Valid_In) begin
          overflow_d = 1'b1;
        end
        if (!Stall_In) begin
          rd_en = 1'b1;
          if (rd_addr_q == LAST_ADDR) begin
            last_rd   = 1'b1;
            rd_addr_d = '0;
            state_d   = IDLE;
          end else begin
            rd_addr_d = rd_addr_q + ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      overflow_q <= overflow_d;
      busy_q     <= (state_d == STREAM);
      valid_q    <= rd_en;
      done_q     <= last_rd;
    end
  end

  frame_buffer_sdp_ram #(
    .WIDTH (W),
    .DEPTH (N),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr_q),
    .wr_data_i (Data_In),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (Data_Out)
  );

  assign Valid_Out  = valid_q;
  assign Frame_Done = done_q;
  assign Busy       = busy_q;
  assign Overflow   = overflow_q;

endmodule

// File: tb/tb_feature_map_frame_streamer.sv
// Randomized bench for feature_map_frame_streamer (4x3 frame) against a
// queue-based frame model, plus literal latency/data pins.
module tb_feature_map_frame_streamer;

  localparam int DW = 32;
  localparam int CH = 16;
  localparam int IW = 4;
  localparam int IH = 3;
  localparam int N  = IW * IH;
  localparam int W  = DW * CH;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] Data_In = '0;
  logic         Valid_In = 1'b0;
  logic         Stall_In = 1'b0;
  logic [W-1:0] Data_Out;
  logic         Valid_Out;
  logic         Frame_Done;
  logic         Busy;
  logic         Overflow;

  always #5 clk = ~clk;

  feature_map_frame_streamer #(
    .DATA_WIDHT (DW),
    .CHANNELS   (CH),
    .IMG_WIDHT  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Data_In    (Data_In),
    .Valid_In   (Valid_In),
    .Stall_In   (Stall_In),
    .Data_Out   (Data_Out),
    .Valid_Out  (Valid_Out),
    .Frame_Done (Frame_Done),
    .Busy       (Busy),
    .Overflow   (Overflow)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] frame_q[$];
  bit           streaming = 0;
  int           rd_idx = 0;
  bit           exp_valid = 0, exp_done = 0, exp_ovf = 0, exp_busy = 0;
  logic [W-1:0] exp_data = '0;
  int           cyc = 0;
  bit           cmp_on = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        frame_q.delete();
        streaming = 0;
        rd_idx    = 0;
        exp_valid = 0;
        exp_done  = 0;
        exp_ovf   = 0;
        exp_busy  = 0;
        exp_data  = '0;
      end else begin
        exp_valid = 0;
        exp_done  = 0;
        if (streaming) begin
          if (Valid_In) exp_ovf = 1;
          if (!Stall_In) begin
            exp_valid = 1;
            exp_data  = frame_q[rd_idx];
            exp_done  = (rd_idx == N - 1);
            rd_idx++;
            if (rd_idx == N) begin
              streaming = 0;
              rd_idx    = 0;
              frame_q.delete();
            end
          end
        end else if (Valid_In) begin
          frame_q.push_back(Data_In);
          if (frame_q.size() == N) streaming = 1;
        end
        exp_busy = streaming;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst && cmp_on) begin
        chk("valid_out", Valid_Out, exp_valid);
        chk("frame_done", Frame_Done, exp_done);
        chk("busy", Busy, exp_busy);
        chk("overflow", Overflow, exp_ovf);
        if (exp_valid) chk("data_out", Data_Out, exp_data);
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [W-1:0] got[$];
  int first_v = -1;
  int last_v  = -1;
  int last_in = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst && Valid_Out) begin
        got.push_back(Data_Out);
        if (first_v < 0) first_v = cyc + 1;
        last_v = cyc + 1;
      end
    end
  end

  task automatic mon_clear();
    got.delete();
    first_v = -1;
    last_v  = -1;
  endtask

  function automatic logic [W-1:0] mk(input int idx, input int mode);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) begin
      if (mode == 0) v[c*DW +: DW] = DW'(idx * 16 + c);
      else           v[c*DW +: DW] = $urandom;
    end
    return v;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic send_frame(input int npix, input int gap_max, input int dmode);
    for (int i = 0; i < npix; i++) begin
      Valid_In = 1'b1;
      Data_In  = mk(i, dmode);
      @(negedge clk);
      Valid_In = 1'b0;
      if (i == npix - 1) begin
        last_in = cyc;
        if (npix == N) chk("busy_rise", Busy, 1'b1);
      end else begin
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
    end
  endtask

  // mode 0: no stall, 1: 3-cycle stall at stream edge 5, 2: random stall and
  // overflow pulses, 3: one overflow pulse. Returns at the Frame_Done negedge.
  task automatic run_stream(input int mode);
    int bc;
    bit done;
    bc   = 0;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (Frame_Done) begin
        done = 1;
      end else begin
        if (Busy) bc++;
        if (mode == 3 && bc == 4) chk("ovf_set", Overflow, 1'b1);
        Stall_In = (mode == 1) ? (bc >= 5 && bc <= 7) :
                   (mode == 2) ? ($urandom_range(3, 0) == 0) : 1'b0;
        Valid_In = (mode == 3 && bc == 3) ||
                   (mode == 2 && Busy && $urandom_range(7, 0) == 0);
        if (Valid_In) Data_In = {CH{32'hDEADBEEF}};
        @(negedge clk);
      end
    end
    Valid_In = 1'b0;
    Stall_In = 1'b0;
    if (!done) chk("stream_timeout", 1'b0, 1'b1);
    chk("out_count", got.size(), N);
    if (mode != 2) begin
      chk("latency", first_v - last_in, 2);
      chk("out_gap", (last_v - first_v + 1) - got.size(), (mode == 1) ? 3 : 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", Data_Out, '0);
    chk("rst_valid", Valid_Out, 1'b0);
    chk("rst_done", Frame_Done, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_ovf", Overflow, 1'b0);
    rst    = 1'b1;
    cmp_on = 1;
    @(negedge clk);

    // dense frame with literal data pins
    mon_clear();
    send_frame(N, 0, 0);
    run_stream(0);
    if (got.size() >= N) begin
      chk("pin_p0c0", got[0][31:0], 32'd0);
      chk("pin_p5c3", got[5][3*DW +: DW], 32'd83);
      chk("pin_p11c15", got[N-1][W-1 -: DW], 32'd191);
    end
    mon_clear();

    // gappy frame
    send_frame(N, 3, 0);
    run_stream(0);
    if (got.size() >= N) chk("gappy_p7c9", got[7][9*DW +: DW], 32'd121);
    mon_clear();

    // stall
    send_frame(N, 2, 1);
    run_stream(1);
    mon_clear();

    // back-to-back frames
    send_frame(N, 0, 1);
    run_stream(0);
    mon_clear();
    send_frame(N, 1, 1);
    run_stream(0);
    chk("b2b_no_ovf", Overflow, 1'b0);
    mon_clear();

    // overflow during stream
    send_frame(N, 1, 0);
    run_stream(3);
    mon_clear();

    // mid-operation reset after 7 pixels
    send_frame(7, 1, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_data", Data_Out, '0);
    chk("mid_rst_valid", Valid_Out, 1'b0);
    chk("mid_rst_done", Frame_Done, 1'b0);
    chk("mid_rst_busy", Busy, 1'b0);
    chk("mid_rst_ovf", Overflow, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mon_clear();
    send_frame(N, 2, 1);
    run_stream(0);
    mon_clear();

    // random frames with random stalls and overflow pulses
    repeat (4) begin
      send_frame(N, 3, 1);
      run_stream(2);
      mon_clear();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/feature_map_frame_streamer.md
# feature_map_frame_streamer

Frame buffer and re-streamer that sits between two separable-convolution stages. It captures one complete 16-channel feature map arriving as a raster pixel stream (`Data_In`/`Valid_In`, the same bus the depthwise channels emit). Once the frame is complete, it replays the frame in raster order as a dense, stallable stream that can drive the next layer's `Data_In`/`Valid_In`. It decouples producer and consumer timing: the producer may emit pixels with arbitrary gaps, while the consumer sees a gap-free burst except where it requests a stall.

## Interface
Parameters:
- `DATA_WIDHT`, 32, width of one channel word (IEEE-754 single).
- `CHANNELS`, 16, channels packed per pixel; channel k occupies bits `[DATA_WIDHT*(k+1)-1 : DATA_WIDHT*k]`.
- `IMG_WIDHT`, 44, pixels per row.
- `IMG_HEIGHT`, 44, rows per frame.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `Data_In` in `DATA_WIDHT*CHANNELS`: incoming pixel, all channels.
- `Valid_In` in 1: `Data_In` is valid this cycle.
- `Stall_In` in 1: downstream requests that no new pixel be issued.
- `Data_Out` out `DATA_WIDHT*CHANNELS`: replayed pixel.
- `Valid_Out` out 1: `Data_Out` is valid this cycle.
- `Frame_Done` out 1: one-cycle pulse, coincident with the `Valid_Out` of the last pixel.
- `Busy` out 1: high while in `STREAM`; the block is not accepting input.
- `Overflow` out 1: sticky; a pixel arrived while `Busy` and was dropped.

## Operation
- Let N = `IMG_WIDHT*IMG_HEIGHT` and AW = clog2(N). There is one write address counter `wr_addr` and one read address counter `rd_addr`, both 0..N-1.
- **IDLE**: `wr_addr` = 0 and `rd_addr` = 0.
  - `Valid_In` writes `Data_In` to address 0, sets `wr_addr` to 1, and moves to `FILL`.
  - If N == 1, it moves directly to `STREAM`.
- **FILL**: each `Valid_In` writes to `wr_addr` and increments it. Cycles without `Valid_In` write nothing.
  - The write at address N-1 moves to `STREAM` on the next edge and clears `wr_addr` to 0.
- **STREAM**: each cycle with `Stall_In` low issues a read at `rd_addr` and increments it.
  - Issuing address N-1 returns to `IDLE` and clears `rd_addr` to 0.
  - `Stall_In` high issues no read; `rd_addr` holds.
  - `Valid_In` in this state drops the pixel and sets `Overflow`. No RAM write occurs.
- The state is 2 bits, using the shared encoding. `DONE` is not a separate state; `Frame_Done` is derived from the read pipeline.
- Data is never modified: `Data_Out` is bit-exact to the captured `Data_In`, and the raster order is preserved.
- **Simultaneous events**:
  - `Valid_In` in the cycle `STREAM` returns to `IDLE` counts as overflow, because the state is still `STREAM`.
  - `Valid_In` on the cycle after the return to `IDLE` starts a new frame at address 0. This is safe because all reads are already issued.
- **Reset**, at any time including mid-frame:
  - State returns to `IDLE`, both counters go to 0, and the read pipeline is cleared.
  - RAM contents are left undefined; they are never read before being rewritten.

## Timing
- Reset values: `Data_Out` = 0, `Valid_Out` = 0, `Frame_Done` = 0, `Busy` = 0, `Overflow` = 0.
- **RAM**: synchronous read with 1-cycle latency. `Data_Out` and `Valid_Out` are registered at the RAM output.
  - A read issued at edge t appears at `Valid_Out` in cycle t+1.
- **Latency**: the last input write occurs at edge t; `STREAM` starts at t+1; the first read issues at t+1; the first `Valid_Out` appears at t+2.
  - With no stall, the frame's N pixels occupy cycles t+2 .. t+N+1 contiguously.
- **Stall**: `Stall_In` sampled high at edge t means no read issues at t, so `Valid_Out` is low at t+1.
  - A read already issued at t-1 still completes (1-deep skid); the consumer must absorb one pixel after asserting the stall.
- **Busy**: registered; equals (state == `STREAM`).
- **Overflow**: set on the edge following the offending `Valid_In`; cleared only by `rst`.
- **Frame_Done**: a one-stage delayed flag of "read address N-1 issued", aligned with the last `Valid_Out`.

## Structure
- The shared package `sep_conv_pkg` holds:
  - the state encoding: `IDLE`=2'd0, `FILL`=2'd1, `STREAM`=2'd2;
  - the N and AW derivation helpers;
  - the default `CHANNELS` = 16.
- One sub-module, `frame_buffer_sdp_ram`: a simple dual-port RAM.
  - One write port and one synchronous read port, parameterised on width (`DATA_WIDHT*CHANNELS`) and depth N.
  - No reset on the array.
- The top level holds the FSM, both counters, the read pipeline register, and the `Overflow` logic.

## Test plan
Tests use `IMG_WIDHT`=4, `IMG_HEIGHT`=3 (N = 12), `CHANNELS`=16, `DATA_WIDHT`=32.

- **Dense frame**: 12 consecutive `Valid_In` pixels, each channel word = pixel index × 16 + channel. Required response: `Busy` rises the cycle after the 12th write; 12 contiguous `Valid_Out` pixels match bit-exact in order; `Frame_Done` is high only with pixel 11.
- **Gappy input**: the same 12 pixels with 0–3 idle cycles between them. Required response: output is identical to the dense case, and the first `Valid_Out` comes 2 cycles after the 12th input.
- **Stall**: `Stall_In` is high for 3 cycles at edge 5 of `STREAM`. Required response: exactly one more pixel after the stall is sampled, then a 3-cycle `Valid_Out` gap, then the output resumes with no pixel lost or duplicated.
- **Overflow**: `Valid_In` is pulsed with 0xDEAD… during `STREAM`. Required response: `Overflow` = 1 the next cycle and stays 1; replayed data is unchanged.
- **Back-to-back frames**: the second frame's first `Valid_In` arrives the cycle after `STREAM` exits. Required response: it is accepted at address 0 with `Overflow` staying 0, and the second frame replays correctly.
- **Mid-operation reset**: `rst` low for 1 cycle after 7 pixels are written. Required response: all outputs go to 0 immediately; a following full 12-pixel frame replays correctly.
